// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic [2:0]        state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            cur, nxt;
  logic [CW-1:0]     cyc, cyc_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              tx_n, busy_n, wrap;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par, par_n;
`endif

  assign wrap     = (cyc == CW'(CLKS_PER_BIT - 1));
  assign tx_ready = (cur == IDLE);
  assign state    = cur;

  always_comb begin
    nxt     = cur;
    cyc_n   = wrap ? '0 : cyc + CW'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    tx_n    = tx_out;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_n   = par;
`endif
    case (cur)
      IDLE: begin
        tx_n  = 1'b1;
        cyc_n = '0;
        bit_n = '0;
        if (tx_valid) begin
          nxt     = START;
          shreg_n = tx_data;
          tx_n    = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_n   = ^tx_data;
`endif
        end
      end
      START: begin
        if (wrap) begin
          nxt  = DATA;
          tx_n = shreg[0];
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_n = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            nxt   = PARITY;
            tx_n  = par;
`else
            nxt   = STOP;
            tx_n  = 1'b1;
`endif
          end else begin
            // shift first so the next bit to emit is always at position 0
            bit_n   = bit_cnt + BW'(1);
            shreg_n = shreg >> 1;
            tx_n    = shreg_n[0];
          end
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        if (wrap) begin
          nxt  = STOP;
          tx_n = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (wrap) nxt = IDLE;
      end
      default: begin
        nxt   = IDLE;
        tx_n  = 1'b1;
        cyc_n = '0;
        bit_n = '0;
      end
    endcase
    busy_n = (nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= IDLE;
      cyc     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      cur     <= nxt;
      cyc     <= cyc_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      tx_out  <= tx_n;
      busy    <= busy_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: an 8-bit/4-clock instance and a 4-bit/1-clock instance.
module tb_serial_frame_tx;

  localparam int CPB = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;
  localparam int NS = 6 + PAR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_out, busy;
  logic [2:0] state;
  logic [3:0] s_data = 4'h0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_out, s_busy;
  logic [2:0] s_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .state(state)
  );

  serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_s (
    .clk(clk), .rst(rst), .tx_data(s_data), .tx_valid(s_valid),
    .tx_ready(s_ready), .tx_out(s_out), .busy(s_busy), .state(s_state)
  );

  typedef struct {
    logic [7:0] d;
    logic [9:0] seq;     // expected line, time order, written MSB first (start .. stop)
    logic       par;
    bit         keep;    // keep tx_valid high through the frame
    logic [7:0] d_after; // tx_data value applied the cycle after accept
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [9:0] seq, input logic par, input int k);
    if (k < 9) return seq[9-k];
    if (PAR == 1 && k == 9) return par;
    return 1'b1;
  endfunction

  function automatic logic [2:0] exp_state(input int k);
    if (k == 0) return 3'd1;
    if (k <= 8) return 3'd2;
    if (PAR == 1 && k == 9) return 3'd3;
    return 3'd4;
  endfunction

  // Called just after a negedge; leaves the bench just after the idle-cycle negedge.
  task automatic run_frame(input vec_t v, input int idx);
    chk($sformatf("v%0d_ready_before", idx), tx_ready, 1);
    tx_data  = v.d;
    tx_valid = 1'b1;
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) begin
          tx_data = v.d_after;
          if (!v.keep) tx_valid = 1'b0;
        end
        chk($sformatf("v%0d_bit%0d_c%0d_out", idx, k, c), tx_out, exp_bit(v.seq, v.par, k));
        chk($sformatf("v%0d_bit%0d_c%0d_state", idx, k, c), state, exp_state(k));
        chk($sformatf("v%0d_bit%0d_c%0d_busy", idx, k, c), busy, 1);
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle_out", idx), tx_out, 1);
    chk($sformatf("v%0d_idle_busy", idx), busy, 0);
    chk($sformatf("v%0d_idle_state", idx), state, 0);
    chk($sformatf("v%0d_idle_ready", idx), tx_ready, 1);
  endtask

  initial begin
    int bad;
    tbl[0] = '{d: 8'hA5, seq: 10'b0101001011, par: 1'b0, keep: 1'b0, d_after: 8'hA5};
    tbl[1] = '{d: 8'h07, seq: 10'b0111000001, par: 1'b1, keep: 1'b0, d_after: 8'h07};
    tbl[2] = '{d: 8'h3C, seq: 10'b0001111001, par: 1'b0, keep: 1'b0, d_after: 8'hFF};
    tbl[3] = '{d: 8'h01, seq: 10'b0100000001, par: 1'b1, keep: 1'b1, d_after: 8'h80};
    tbl[4] = '{d: 8'h80, seq: 10'b0000000011, par: 1'b1, keep: 1'b0, d_after: 8'h80};

    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_out", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_s_out", s_out, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out", tx_out, 1);

    for (int i = 0; i < 5; i++) run_frame(tbl[i], i);

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (state != 3'd0 || tx_out != 1'b1 || busy != 1'b0) bad++;
    end
    chk("no_extra_frame", bad, 0);

    // Narrow instance: 4'b1001, one clock per bit.
    s_data  = 4'b1001;
    s_valid = 1'b1;
    for (int k = 0; k < NS; k++) begin
      logic [5:0] e6;
      logic       eb;
      e6 = 6'b010011;
      if (k < 5) eb = e6[5-k];
      else if (PAR == 1 && k == 5) eb = 1'b0;
      else eb = 1'b1;
      @(negedge clk);
      if (k == 0) s_valid = 1'b0;
      chk($sformatf("small_bit%0d", k), s_out, eb);
    end
    @(negedge clk);
    chk("small_idle_state", s_state, 0);
    chk("small_idle_busy", s_busy, 0);
    chk("small_idle_out", s_out, 1);

    // Reset in the middle of the data bits.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (n == 0) tx_valid = 1'b0;
    end
    chk("mid_state_before_rst", state, 2);
    rst = 1'b1;
    #1;
    chk("abort_out", tx_out, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", tx_ready, 1);
    chk("abort_state", state, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx_out != 1'b1 || state != 3'd0) bad++;
    end
    chk("line_high_after_abort", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
